uart_instr_loader: RTL and testbench
====================================

# uart_instr_loader

Receives a program over a UART serial line and writes it word by word into the instruction memory that the control FSM fetches from. It is the write side of the instruction memory: the FSM drives the read port, and this block drives the write port. It contains an 8N1 UART receiver, a framing state machine, 32-bit word assembly, an address counter and checksum checking. It also outputs `load_busy`, so the top level can hold the control FSM in reset while a program is loading.

## Interface
- `F_CLK`, 50_000_000, system clock frequency in Hz
- `BAUD`, 921_600, serial bit rate
- `CLK_PER_BIT`, F_CLK / BAUD (54 at the defaults), clock cycles per serial bit
- `INSTR_WIDTH`, 32, instruction word width; fixed at 4 bytes
- `INSTR_DEPTH`, 256, number of instruction memory words
- `PC_WIDTH`, $clog2(INSTR_DEPTH), width of the write address
- `clk`  in  1  single system clock; all logic is clocked on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `uart_rx`  in  1  asynchronous serial input; idles high
- `wr_en`  out  1  instruction memory write strobe, one cycle per word
- `wr_addr`  out  PC_WIDTH  instruction memory write address
- `wr_data`  out  INSTR_WIDTH  instruction memory write data
- `load_busy`  out  1  high while a frame is in progress
- `load_done`  out  1  level; set when a frame completes with a good checksum
- `load_err`  out  1  sticky level; set on a checksum, framing or overflow error
- `rx_byte_out`  out  8  last received byte (debug)
- `rx_byte_valid`  out  1  one-cycle pulse for each received byte (debug)

## Operation
- **RX synchroniser.** `uart_rx` passes through a 2-flop synchroniser; its reset value is 1.
- **RX FSM states:** RX_IDLE, RX_START, RX_DATA, RX_STOP.
  - RX_IDLE: a synchronised low level moves to RX_START.
  - RX_START: waits CLK_PER_BIT/2 cycles. If the line is still low, go to RX_DATA; otherwise it was a glitch, go back to RX_IDLE.
  - RX_DATA: samples 8 bits, one every CLK_PER_BIT cycles, LSB first.
  - RX_STOP: samples the stop bit CLK_PER_BIT cycles later. If it is high, pulse `rx_byte_valid` and update `rx_byte_out`. If it is low, this is a framing error: no valid pulse, and a one-cycle internal `rx_ferr` pulse. Both cases return to RX_IDLE.
- **Frame format:** `0xA5` start, count byte N, then 4·N data bytes, then a checksum byte.
  - N = 0 means 256 words.
  - Data bytes are little-endian per word: `wr_data = {b3,b2,b1,b0}`.
  - The checksum is the XOR of all data bytes. The start byte and count byte are excluded.
- **Loader FSM states:** L_IDLE, L_COUNT, L_DATA, L_CSUM.
  - L_IDLE: bytes other than 0xA5 are ignored. On 0xA5: clear `load_done` and `load_err`, set `wr_addr` to 0, clear the checksum, and go to L_COUNT.
  - L_COUNT: latch N into a 9-bit word counter (0 → 256), then go to L_DATA.
  - L_DATA: shift each byte into the word register and XOR it into the checksum. On every 4th byte, pulse `wr_en` and decrement the word counter. When the counter reaches 0, go to L_CSUM.
  - L_CSUM: compare the received byte with the running checksum. If they match, set `load_done`; otherwise set `load_err`. Return to L_IDLE.
- **`load_busy`:** equals (loader state ≠ L_IDLE).
- **`wr_addr` increment:** `wr_addr` increments in the cycle after each `wr_en`.
- **Boundary: overflow.** If N is greater than INSTR_DEPTH, writes with an address ≥ INSTR_DEPTH are suppressed (`wr_en` stays 0) and `load_err` is set. `wr_addr` never wraps to overwrite word 0.
- **Boundary: framing error in L_COUNT, L_DATA or L_CSUM.** Set `load_err`, abort to L_IDLE, and issue no further writes.
- **Boundary: bad checksum.** Words already written stay in memory. `load_err` marks the program as invalid.
- **Boundary: reset mid-frame.** Both FSMs return to idle. All outputs return to their reset values; no partial word is written.

## Timing
- **Reset values:** `wr_en`=0, `wr_addr`=0, `wr_data`=0, `load_busy`=0, `load_done`=0, `load_err`=0, `rx_byte_out`=0, `rx_byte_valid`=0.
- **Byte latency:**
  - Line sampling is delayed 2 cycles by the synchroniser.
  - Bits are sampled at mid-bit.
  - `rx_byte_valid` rises at the stop-bit sample, about 9.5·CLK_PER_BIT + 2 cycles after the start edge.
- **Write timing:**
  - `wr_en`, `wr_addr` and `wr_data` are all registered.
  - `wr_en` is high for exactly one cycle, in the cycle after the `rx_byte_valid` of the 4th byte.
  - `wr_data` and `wr_addr` are stable during that cycle.
- **Flag timing:** `load_done` and `load_err` update in the cycle after the `rx_byte_valid` of the checksum byte. `load_busy` falls in the same cycle.
- **Throughput:** at most one byte every 10·CLK_PER_BIT cycles, so writes are always at least 40·CLK_PER_BIT cycles apart. No backpressure is needed.

## Test plan
- **Single word.** Send A5 01 13 00 00 80 93 at 54 clk/bit → one `wr_en` with `wr_addr`=0 and `wr_data`=0x80000013; then `load_done`=1, `load_err`=0, `load_busy`=0.
- **Three words.** Send A5 03, then 12 bytes, then a correct checksum → `wr_en` at addresses 0, 1, 2 with the correct little-endian data; `load_done`=1.
- **Bad checksum.** Send the single-word frame with the checksum byte as 0x00 → word written at address 0; `load_err`=1, `load_done`=0. A following good frame clears `load_err` at its 0xA5.
- **Noise and glitches.** Send bytes 0x00 0xFF 0x13 before A5, plus a 10-cycle low glitch on the idle line → no writes and no `rx_byte_valid` for the glitch; the following frame loads normally.
- **Framing error.** Force the stop bit low on the 2nd data byte → abort, `load_err`=1, `load_busy`=0, no `wr_en`.
- **Reset mid-frame.** Assert `rst` for 1 cycle after 2 data bytes → all outputs return to reset values; a fresh frame then writes starting at `wr_addr`=0.

Source files
------------

// File: rtl/uart_instr_loader.sv
// rtl/uart_instr_loader.sv - 8N1 UART receiver feeding a framed instruction-memory write port
module uart_instr_loader #(
    parameter int F_CLK       = 50_000_000,
    parameter int BAUD        = 921_600,
    parameter int CLK_PER_BIT = F_CLK / BAUD,
    parameter int INSTR_WIDTH = 32,
    parameter int INSTR_DEPTH = 256,
    parameter int PC_WIDTH    = $clog2(INSTR_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   uart_rx,
    output logic                   wr_en,
    output logic [PC_WIDTH-1:0]    wr_addr,
    output logic [INSTR_WIDTH-1:0] wr_data,
    output logic                   load_busy,
    output logic                   load_done,
    output logic                   load_err,
    output logic [7:0]             rx_byte_out,
    output logic                   rx_byte_valid
);
    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    localparam logic [1:0] L_IDLE  = 2'd0;
    localparam logic [1:0] L_COUNT = 2'd1;
    localparam logic [1:0] L_DATA  = 2'd2;
    localparam logic [1:0] L_CSUM  = 2'd3;

    localparam logic [15:0] BIT_END  = 16'(CLK_PER_BIT - 1);
    localparam logic [15:0] HALF_END = 16'(CLK_PER_BIT / 2 - 1);

    logic        rx_meta, rx_s;
    logic [1:0]  rx_state;
    logic [15:0] rx_cnt;
    logic [2:0]  rx_bit;
    logic [7:0]  rx_shift;
    logic        rx_ferr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta       <= 1'b1;
            rx_s          <= 1'b1;
            rx_state      <= RX_IDLE;
            rx_cnt        <= '0;
            rx_bit        <= '0;
            rx_shift      <= '0;
            rx_byte_out   <= '0;
            rx_byte_valid <= 1'b0;
            rx_ferr       <= 1'b0;
        end else begin
            rx_meta       <= uart_rx;
            rx_s          <= rx_meta;
            rx_byte_valid <= 1'b0;
            rx_ferr       <= 1'b0;
            case (rx_state)
                RX_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_s) rx_state <= RX_START;
                end
                RX_START: begin
                    if (rx_cnt == HALF_END) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                RX_DATA: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= RX_STOP;
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
                default: begin
                    if (rx_cnt == BIT_END) begin
                        rx_cnt   <= '0;
                        rx_state <= RX_IDLE;
                        if (rx_s) begin
                            rx_byte_valid <= 1'b1;
                            rx_byte_out   <= rx_shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 16'd1;
                    end
                end
            endcase
        end
    end

    logic [1:0]             l_state;
    logic [8:0]             word_cnt;
    logic [1:0]             byte_idx;
    logic [INSTR_WIDTH-9:0] word_lo;
    logic [7:0]             csum;
    logic                   mem_full;

    assign load_busy = (l_state != L_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            l_state   <= L_IDLE;
            word_cnt  <= '0;
            byte_idx  <= '0;
            word_lo   <= '0;
            csum      <= '0;
            mem_full  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            // Saturate at the last word instead of wrapping back onto word 0.
            if (wr_en) begin
                if (wr_addr == PC_WIDTH'(INSTR_DEPTH - 1)) mem_full <= 1'b1;
                else wr_addr <= wr_addr + 1'b1;
            end
            if (rx_ferr && l_state != L_IDLE) begin
                load_err <= 1'b1;
                l_state  <= L_IDLE;
            end else if (rx_byte_valid) begin
                case (l_state)
                    L_IDLE: begin
                        if (rx_byte_out == 8'hA5) begin
                            load_done <= 1'b0;
                            load_err  <= 1'b0;
                            wr_addr   <= '0;
                            mem_full  <= 1'b0;
                            csum      <= '0;
                            l_state   <= L_COUNT;
                        end
                    end
                    L_COUNT: begin
                        word_cnt <= (rx_byte_out == 8'd0) ? 9'd256 : {1'b0, rx_byte_out};
                        byte_idx <= '0;
                        l_state  <= L_DATA;
                    end
                    L_DATA: begin
                        word_lo  <= {rx_byte_out, word_lo[INSTR_WIDTH-9:8]};
                        csum     <= csum ^ rx_byte_out;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == 2'd3) begin
                            wr_data  <= {rx_byte_out, word_lo};
                            word_cnt <= word_cnt - 9'd1;
                            if (mem_full) load_err <= 1'b1;
                            else wr_en <= 1'b1;
                            if (word_cnt == 9'd1) l_state <= L_CSUM;
                        end
                    end
                    default: begin
                        if (rx_byte_out == csum && !load_err) load_done <= 1'b1;
                        else load_err <= 1'b1;
                        l_state <= L_IDLE;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_uart_instr_loader.sv
// tb/tb_uart_instr_loader.sv - directed bench for the UART instruction loader
module tb_uart_instr_loader;
    localparam int CPB = 54;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        uart_rx = 1'b1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [31:0] wr_data;
    logic        load_busy, load_done, load_err;
    logic [7:0]  rx_byte_out;
    logic        rx_byte_valid;

    int n_cmp = 0;
    int n_bad = 0;
    int n_valid = 0;
    logic [7:0]  wa[$];
    logic [31:0] wd[$];
    logic [7:0]  txq[$];

    uart_instr_loader dut (
        .clk(clk), .rst(rst), .uart_rx(uart_rx),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .load_busy(load_busy), .load_done(load_done), .load_err(load_err),
        .rx_byte_out(rx_byte_out), .rx_byte_valid(rx_byte_valid)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
        end
        if (rx_byte_valid) n_valid++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
    endtask

    task automatic send_q();
        for (int i = 0; i < txq.size(); i++) send_byte(txq[i], 1'b1);
        txq.delete();
        repeat (20) @(negedge clk);
    endtask

    task automatic clear_log();
        wa.delete();
        wd.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_addr"}, wr_addr, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_busy"}, load_busy, 0);
        check({tag, "_done"}, load_done, 0);
        check({tag, "_err"}, load_err, 0);
        check({tag, "_rx_byte"}, rx_byte_out, 0);
        check({tag, "_rx_valid"}, rx_byte_valid, 0);
    endtask

    initial begin
        int nv;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");

        // single word
        send_byte(8'hA5, 1'b1);
        check("single_busy_mid", load_busy, 1);
        txq = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h80, 8'h93};
        send_q();
        check("single_nwr", wa.size(), 1);
        if (wa.size() >= 1) begin
            check("single_addr", wa[0], 8'h00);
            check("single_data", wd[0], 32'h8000_0013);
        end
        check("single_done", load_done, 1);
        check("single_err", load_err, 0);
        check("single_busy", load_busy, 0);
        check("single_last_byte", rx_byte_out, 8'h93);
        clear_log();

        // three words
        txq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h20, 8'h30, 8'h40,
                8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
        send_q();
        check("three_nwr", wa.size(), 3);
        if (wa.size() >= 3) begin
            check("three_addr0", wa[0], 0);
            check("three_addr1", wa[1], 1);
            check("three_addr2", wa[2], 2);
            check("three_data0", wd[0], 32'h0403_0201);
            check("three_data1", wd[1], 32'h4030_2010);
            check("three_data2", wd[2], 32'hDDCC_BBAA);
        end
        check("three_done", load_done, 1);
        check("three_err", load_err, 0);
        clear_log();

        // bad checksum, then recovery
        txq = '{8'hA5, 8'h01, 8'h13, 8'h00, 8'h00, 8'h80, 8'h00};
        send_q();
        check("badcs_nwr", wa.size(), 1);
        if (wa.size() >= 1) check("badcs_addr", wa[0], 0);
        check("badcs_err", load_err, 1);
        check("badcs_done", load_done, 0);
        send_byte(8'hA5, 1'b1);
        repeat (5) @(negedge clk);
        check("recover_err_clear", load_err, 0);
        txq = '{8'h01, 8'h13, 8'h00, 8'h00, 8'h80, 8'h93};
        send_q();
        check("recover_done", load_done, 1);
        clear_log();

        // glitch and noise
        nv = n_valid;
        uart_rx = 1'b0;
        repeat (10) @(negedge clk);
        uart_rx = 1'b1;
        repeat (200) @(negedge clk);
        check("glitch_no_valid", n_valid - nv, 0);
        txq = '{8'h00, 8'hFF, 8'h13};
        send_q();
        check("noise_valids", n_valid - nv, 3);
        check("noise_nwr", wa.size(), 0);
        check("noise_busy", load_busy, 0);
        txq = '{8'hA5, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h22};
        send_q();
        check("noise_frame_nwr", wa.size(), 1);
        if (wa.size() >= 1) check("noise_frame_data", wd[0], 32'hDEAD_BEEF);
        check("noise_frame_done", load_done, 1);
        clear_log();

        // framing error on second data byte
        txq = '{8'hA5, 8'h02, 8'h11};
        send_q();
        send_byte(8'h22, 1'b0);
        repeat (300) @(negedge clk);
        check("ferr_err", load_err, 1);
        check("ferr_busy", load_busy, 0);
        check("ferr_done", load_done, 0);
        check("ferr_nwr", wa.size(), 0);
        clear_log();

        // reset mid-frame
        txq = '{8'hA5, 8'h01, 8'h11, 8'h22};
        send_q();
        check("midrst_busy_before", load_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("midrst");
        repeat (100) @(negedge clk);
        check("midrst_nwr", wa.size(), 0);
        txq = '{8'hA5, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h03};
        send_q();
        check("fresh_nwr", wa.size(), 2);
        if (wa.size() >= 2) begin
            check("fresh_addr0", wa[0], 0);
            check("fresh_addr1", wa[1], 1);
            check("fresh_data0", wd[0], 32'h0000_0001);
            check("fresh_data1", wd[1], 32'h0000_0002);
        end
        check("fresh_done", load_done, 1);
        check("fresh_err", load_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
